// File: rtl/proc_sequencer_if.sv
// Processor-side handshake bundle between proc_sequencer and the 9-bit core.
// The sequencer owns DIN/Run; the core answers with Done and its bus value.
interface proc_sequencer_if;
  logic [8:0] DIN;
  logic       Run;
  logic       Done;
  logic [8:0] BusWires;

  modport master (output DIN, output Run, input Done, input BusWires);
  modport slave  (input DIN, input Run, output Done, output BusWires);
endinterface

// File: rtl/proc_sequencer.sv
// Instruction sequencer for the 9-bit processor: holds a loadable program,
// issues one instruction per Run strobe, supplies mvi immediates and waits
// for Done before advancing.
// Optional watchdog: define SEQ_WATCHDOG_EN to halt with Error after 16
// consecutive IMM/WAIT cycles without Done.
module proc_sequencer #(
  parameter int AW = 4
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                LdEn,
  input  logic [AW-1:0]       LdAddr,
  input  logic [8:0]          LdData,
  input  logic                Start,
  proc_sequencer_if.master    bus,
  output logic                Busy,
  output logic                Halted,
  output logic [AW-1:0]       PC,
  output logic [8:0]          LastBus,
  output logic [7:0]          InstrCount,
  output logic                Error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int         DEPTH   = 2 ** AW;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t     state, next_state;
  logic [8:0] mem [DEPTH];
  logic [8:0] cur_word, imm_word;
  logic [8:0] din, din_hold;
  logic       run, retire, start_ok, load_ok;
  logic       is_mvi;
  logic       wd_expire;

  // Immediate address wraps naturally at AW bits (mvi at top fetches word 0)
  assign cur_word = mem[PC];
  assign imm_word = mem[PC + AW'(1)];

  assign bus.DIN = din;
  assign bus.Run = run;

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // Next-state decode and per-state outputs
  always_comb begin
    next_state = state;
    din        = din_hold;
    run        = 1'b0;
    retire     = 1'b0;
    start_ok   = 1'b0;
    load_ok    = 1'b0;
    Busy       = 1'b0;
    Halted     = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        load_ok = 1'b1;
        Halted  = (state == S_HALT);
        if (Start) begin
          start_ok   = 1'b1;
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        Busy = 1'b1;
        din  = cur_word;
        if (cur_word[8:6] == OP_HALT) begin
          next_state = S_HALT;
        end else begin
          run        = 1'b1;
          next_state = (cur_word[8:6] == OP_MVI) ? S_IMM : S_WAIT;
        end
      end
      S_IMM: begin
        Busy = 1'b1;
        din  = imm_word;
        if (bus.Done) begin
          retire     = 1'b1;
          next_state = S_ISSUE;
        end else if (wd_expire) begin
          next_state = S_HALT;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        Busy = 1'b1;
        if (bus.Done) begin
          retire     = 1'b1;
          next_state = S_ISSUE;
        end else if (wd_expire) begin
          next_state = S_HALT;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Program counter, retire bookkeeping and DIN hold register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      PC         <= '0;
      LastBus    <= '0;
      InstrCount <= '0;
      din_hold   <= '0;
      is_mvi     <= 1'b0;
    end else begin
      din_hold <= din;
      if (state == S_ISSUE) is_mvi <= (cur_word[8:6] == OP_MVI);
      if (start_ok) begin
        PC         <= '0;
        InstrCount <= '0;
      end else if (retire) begin
        PC      <= PC + (is_mvi ? AW'(2) : AW'(1));
        LastBus <= bus.BusWires;
        if (InstrCount != 8'hFF) InstrCount <= InstrCount + 8'd1;
      end
    end
  end

  // Program memory write port; locked out while an instruction is in flight
  always_ff @(posedge Clock) begin
    if (LdEn && load_ok) mem[LdAddr] <= LdData;
  end

`ifdef SEQ_WATCHDOG_EN
  logic [3:0] wd_cnt;

  assign wd_expire = ((state == S_IMM) || (state == S_WAIT)) && !bus.Done && (wd_cnt == 4'hF);

  // Count consecutive IMM/WAIT cycles without Done; restart at every issue
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                                           wd_cnt <= '0;
    else if (state == S_ISSUE)                             wd_cnt <= '0;
    else if (((state == S_IMM) || (state == S_WAIT)) && !bus.Done) wd_cnt <= wd_cnt + 4'd1;
  end

  // Sticky timeout flag, cleared by a new Start
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)        Error <= 1'b0;
    else if (start_ok)  Error <= 1'b0;
    else if (wd_expire) Error <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  assign Error     = 1'b0;
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
// Testbench for proc_sequencer: randomized programs, a processor responder
// with random Done latency, and a scoreboard of expected issues.
module tb_proc_sequencer;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          LdEn = 1'b0;
  logic [AW-1:0] LdAddr = '0;
  logic [8:0]    LdData = '0;
  logic          Start = 1'b0;
  logic          Busy, Halted, Error;
  logic [AW-1:0] PC;
  logic [8:0]    LastBus;
  logic [7:0]    InstrCount;

  proc_sequencer_if bus_if ();

  proc_sequencer #(.AW(AW)) dut (
    .Clock(Clock), .Resetn(Resetn), .LdEn(LdEn), .LdAddr(LdAddr),
    .LdData(LdData), .Start(Start), .bus(bus_if), .Busy(Busy),
    .Halted(Halted), .PC(PC), .LastBus(LastBus), .InstrCount(InstrCount),
    .Error(Error)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         pc;
    logic [8:0] word;
    logic [8:0] imm;
    bit         mvi;
  } exp_t;

  exp_t       exp_q[$];
  int         lat_q[$];
  logic [8:0] m [DEPTH];
  logic [8:0] last_bus_exp = '0;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Processor stand-in: answers each Run with Done after a queued latency
  initial begin
    int left;
    left = 0;
    forever begin
      @(negedge Clock);
      bus_if.BusWires = 9'($urandom);
      if (!Resetn || !Busy) begin
        bus_if.Done = 1'b0;
        left = 0;
      end else if (bus_if.Run) begin
        bus_if.Done = 1'b0;
        left = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      end else if (left > 0) begin
        left--;
        bus_if.Done = (left == 0);
        if (left == 0) last_bus_exp = bus_if.BusWires;
      end else begin
        bus_if.Done = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every Run must match the next expected issue
  initial begin
    exp_t       e;
    bit         pend_imm;
    logic [8:0] pend_val;
    pend_imm = 1'b0;
    pend_val = '0;
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        pend_imm = 1'b0;
      end else begin
        if (pend_imm) begin
          check("imm_din", bus_if.DIN, pend_val);
          pend_imm = 1'b0;
        end
        if (bus_if.Run) begin
          if (exp_q.size() == 0) begin
            check("unexpected_run_pc", PC, 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            check("issue_cycle", cyc, e.at);
            check("issue_pc", PC, e.pc);
            check("issue_din", bus_if.DIN, e.word);
            if (e.mvi) begin
              pend_imm = 1'b1;
              pend_val = e.imm;
            end
          end
        end
      end
    end
  end

  // Reference model: walk the program from address 0, one entry per issue
  task automatic model_run(input int start_cyc, input int max_n, input int fixed_lat,
                           output int n, output int end_pc, output int end_cyc,
                           output bit halted);
    int pc, c, lat;
    logic [8:0] w;
    exp_t e;
    pc = 0; c = start_cyc; n = 0; halted = 1'b0;
    while (n < max_n) begin
      w = m[pc];
      if (w[8:6] == 3'b111) begin
        halted = 1'b1;
        break;
      end
      if (fixed_lat > 0)                        lat = fixed_lat;
      else if (w[8:6] == 3'b010 || w[8:6] == 3'b011) lat = $urandom_range(3, 5);
      else if (w[8:6] <= 3'b001)                lat = $urandom_range(1, 3);
      else                                      lat = $urandom_range(1, 4);
      lat_q.push_back(lat);
      e.at = c; e.pc = pc; e.word = w; e.imm = m[(pc + 1) % DEPTH];
      e.mvi = (w[8:6] == 3'b001);
      exp_q.push_back(e);
      n++;
      c  = c + lat + 1;
      pc = (pc + (e.mvi ? 2 : 1)) % DEPTH;
    end
    end_pc  = pc;
    end_cyc = c;
  endtask

  function automatic int halt_steps();
    int pc;
    pc = 0;
    for (int i = 0; i < 40; i++) begin
      if (m[pc][8:6] == 3'b111) return i;
      pc = (pc + ((m[pc][8:6] == 3'b001) ? 2 : 1)) % DEPTH;
    end
    return -1;
  endfunction

  function automatic int pc_after(input int k);
    int pc;
    pc = 0;
    for (int i = 0; i < k; i++) pc = (pc + ((m[pc][8:6] == 3'b001) ? 2 : 1)) % DEPTH;
    return pc;
  endfunction

  task automatic load_word(input int a, input logic [8:0] d);
    LdEn = 1'b1; LdAddr = AW'(a); LdData = d; m[a] = d;
    @(negedge Clock);
    LdEn = 1'b0;
  endtask

  task automatic ensure_halt();
    if (halt_steps() < 0) load_word(pc_after(3), 9'h1C0);
  endtask

  task automatic reset_pulse();
    #2 Resetn = 1'b0;
    #1;
    check("rst_run", bus_if.Run, 0);
    check("rst_busy", Busy, 0);
    check("rst_pc", PC, 0);
    check("rst_din", bus_if.DIN, 0);
    check("rst_count", InstrCount, 0);
    check("rst_lastbus", LastBus, 0);
    exp_q.delete();
    lat_q.delete();
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  // Start a program from IDLE/HALT and check the halted end state
  task automatic run_program(input int fixed_lat, input bit same_load, input bit inject);
    int n, end_pc, end_cyc, a;
    bit halted, injected;
    logic [8:0] prev_last, d;
    prev_last = LastBus;
    injected = 1'b0;
    if (same_load) begin
      a = $urandom_range(0, DEPTH - 1);
      d = 9'($urandom);
      m[a] = d;
      if (halt_steps() < 0) begin
        d = 9'h1C0;
        m[a] = d;
      end
      LdEn = 1'b1; LdAddr = AW'(a); LdData = d;
    end
    Start = 1'b1;
    model_run(cyc + 1, 64, fixed_lat, n, end_pc, end_cyc, halted);
    @(negedge Clock);
    Start = 1'b0;
    LdEn  = 1'b0;
    while (cyc < end_cyc + 1) begin
      if (cyc == end_cyc) check("halted_early", Halted, 0);
      if (inject && !injected && Busy && $urandom_range(0, 2) == 0) begin
        a = $urandom_range(0, DEPTH - 1);
        LdEn = 1'b1; LdAddr = AW'(a); LdData = m[a] ^ 9'h1FF;
        injected = 1'b1;
      end
      @(negedge Clock);
      LdEn = 1'b0;
    end
    check("halted", Halted, 1);
    check("busy_after_halt", Busy, 0);
    check("end_pc", PC, end_pc);
    check("instr_count", InstrCount, (n > 255) ? 255 : n);
    check("error_clear", Error, 0);
    check("last_bus", LastBus, (n > 0) ? last_bus_exp : prev_last);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n, end_pc, end_cyc, s;
    bit halted;
    repeat (3) @(negedge Clock);
    check("reset_din", bus_if.DIN, 0);
    check("reset_run", bus_if.Run, 0);
    check("reset_busy", Busy, 0);
    check("reset_halted", Halted, 0);
    check("reset_pc", PC, 0);
    check("reset_lastbus", LastBus, 0);
    check("reset_count", InstrCount, 0);
    check("reset_error", Error, 0);
    Resetn = 1'b1;
    @(negedge Clock);
    for (int i = 0; i < DEPTH; i++) load_word(i, 9'($urandom));

    // mvi R0,#5 then halt
    load_word(0, 9'h040); load_word(1, 9'h005); load_word(2, 9'h1C0);
    run_program(0, 1'b0, 1'b0);

    // add R1,R0 answered 3 cycles after issue, then halt
    load_word(0, 9'h088); load_word(1, 9'h1C0);
    run_program(3, 1'b0, 1'b0);

    // mvi at the top address takes its immediate from address 0
    load_word(0, 9'h040); load_word(1, 9'h1C0);
    for (int i = 2; i < DEPTH - 1; i++) load_word(i, 9'h008);
    load_word(DEPTH - 1, 9'h050);
    run_program(0, 1'b0, 1'b1);

    // Reset while the mvi immediate is on DIN
    load_word(0, 9'h040); load_word(1, 9'h005); load_word(2, 9'h1C0);
    Start = 1'b1;
    s = cyc + 1;
    model_run(s, 64, 0, n, end_pc, end_cyc, halted);
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    check("imm_state_busy", Busy, 1);
    reset_pulse();
    run_program(0, 1'b0, 1'b0);

    // Endless mv loop: InstrCount saturates at 255
    for (int i = 0; i < DEPTH; i++) load_word(i, 9'h008);
    Start = 1'b1;
    s = cyc + 1;
    model_run(s, 300, 1, n, end_pc, end_cyc, halted);
    @(negedge Clock);
    Start = 1'b0;
    while (cyc < s + 2 * 254) @(negedge Clock);
    check("count_254", InstrCount, 254);
    while (cyc < s + 2 * 255) @(negedge Clock);
    check("count_255", InstrCount, 255);
    while (cyc < s + 2 * 299) @(negedge Clock);
    check("count_saturated", InstrCount, 255);
    check("sat_busy", Busy, 1);
    reset_pulse();

    // Done withheld on an add
    load_word(0, 9'h088); load_word(1, 9'h1C0);
    Start = 1'b1;
    s = cyc + 1;
    begin
      exp_t e;
      e.at = s; e.pc = 0; e.word = 9'h088; e.imm = 9'h1C0; e.mvi = 1'b0;
      exp_q.push_back(e);
      lat_q.push_back(100000);
    end
    @(negedge Clock);
    Start = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    while (cyc < s + 16) @(negedge Clock);
    check("wd_not_yet_halted", Halted, 0);
    check("wd_still_busy", Busy, 1);
    @(negedge Clock);
    check("wd_halted", Halted, 1);
    check("wd_error", Error, 1);
    check("wd_pc", PC, 0);
`else
    while (cyc < s + 120) @(negedge Clock);
    check("nowd_busy", Busy, 1);
    check("nowd_error", Error, 0);
    check("nowd_halted", Halted, 0);
    reset_pulse();
`endif

    // Randomized programs with partial reloads and ignored busy writes
    for (int it = 0; it < 12; it++) begin
      int k;
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) load_word($urandom_range(0, DEPTH - 1), 9'($urandom));
      ensure_halt();
      run_program(0, 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
